// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - branch/jump resolver with result hold and front-end flush sequencing
// Optional statistics counters are compiled in with `define BRC_STATS_EN.
module branch_resolve_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_taken,
    output logic [31:0] out_target,
    output logic [31:0] out_link,
    output logic        out_illegal,
    output logic        out_misalign,
    output logic        flush,
    output logic        busy,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_taken
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESULT = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    state_e      state_q;
    logic        in_ready_q, out_valid_q, flush_q, busy_q;
    logic        taken_q, illegal_q, misalign_q;
    logic [31:0] target_q, link_q;
    logic [2:0]  cnt_q;

    logic        taken_d, illegal_d, misalign_d;
    logic [31:0] target_d, link_d;
    logic [31:0] pc_imm, jalr_tgt;

    // Result is resolved from the live inputs and registered at accept time,
    // so later input changes cannot leak into the held result.
    always_comb begin
        pc_imm    = in_pc + in_imm;
        jalr_tgt  = (in_rs1 + in_imm) & 32'hFFFF_FFFE;
        link_d    = in_pc + 32'd4;
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        target_d  = link_d;
        unique case (in_opcode)
            OP_BRANCH: begin
                target_d = pc_imm;
                unique case (in_funct3)
                    3'b000:  taken_d = (in_rs1 == in_rs2);
                    3'b001:  taken_d = (in_rs1 != in_rs2);
                    3'b100:  taken_d = ($signed(in_rs1) <  $signed(in_rs2));
                    3'b101:  taken_d = ($signed(in_rs1) >= $signed(in_rs2));
                    3'b110:  taken_d = (in_rs1 <  in_rs2);
                    3'b111:  taken_d = (in_rs1 >= in_rs2);
                    default: begin
                        illegal_d = 1'b1;
                        target_d  = link_d;
                    end
                endcase
            end
            OP_JAL: begin
                taken_d  = 1'b1;
                target_d = pc_imm;
            end
            OP_JALR: begin
                taken_d  = 1'b1;
                target_d = jalr_tgt;
            end
            default: illegal_d = 1'b1;
        endcase
        misalign_d = taken_d && (target_d[1:0] != 2'b00);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
            misalign_q  <= 1'b0;
            target_q    <= 32'd0;
            link_q      <= 32'd0;
            cnt_q       <= 3'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q     <= RESULT;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        taken_q     <= taken_d;
                        illegal_q   <= illegal_d;
                        misalign_q  <= misalign_d;
                        target_q    <= target_d;
                        link_q      <= link_d;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (taken_q && !illegal_q && !misalign_q) begin
                            state_q <= FLUSH;
                            flush_q <= 1'b1;
                            cnt_q   <= FLUSH_INIT;
                        end else begin
                            state_q    <= IDLE;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (cnt_q == 3'd0) begin
                        state_q    <= IDLE;
                        flush_q    <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    flush_q    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_taken    = taken_q;
    assign out_target   = target_q;
    assign out_link     = link_q;
    assign out_illegal  = illegal_q;
    assign out_misalign = misalign_q;
    assign flush        = flush_q;
    assign busy         = busy_q;

`ifdef BRC_STATS_EN
    logic        is_cbr, is_cbr_q;
    logic [31:0] stat_br_q, stat_tk_q;

    assign is_cbr = (in_opcode == OP_BRANCH) && (in_funct3[2:1] != 2'b01);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            is_cbr_q  <= 1'b0;
            stat_br_q <= 32'd0;
            stat_tk_q <= 32'd0;
        end else begin
            if (state_q == IDLE && in_valid)
                is_cbr_q <= is_cbr;
            if (state_q == RESULT && out_ready && is_cbr_q) begin
                if (stat_br_q != 32'hFFFF_FFFF)
                    stat_br_q <= stat_br_q + 32'd1;
                if (taken_q && stat_tk_q != 32'hFFFF_FFFF)
                    stat_tk_q <= stat_tk_q + 32'd1;
            end
        end
    end

    assign stat_branches = stat_br_q;
    assign stat_taken    = stat_tk_q;
`else
    assign stat_branches = 32'd0;
    assign stat_taken    = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

    localparam int FC = 2;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_pc = '0, in_imm = '0, in_rs1 = '0, in_rs2 = '0;
    logic        out_valid, out_ready = 1'b0;
    logic        out_taken, out_illegal, out_misalign, flush, busy;
    logic [31:0] out_target, out_link, stat_branches, stat_taken;

    int checks = 0;
    int failures = 0;
    int exp_br = 0;
    int exp_tk = 0;

    always #5 CLK = ~CLK;

    branch_resolve_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3),
        .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target), .out_link(out_link),
        .out_illegal(out_illegal), .out_misalign(out_misalign),
        .flush(flush), .busy(busy),
        .stat_branches(stat_branches), .stat_taken(stat_taken)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; accepts on the next posedge, then scrambles the inputs.
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2);
        check_eq("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1; in_opcode = op; in_funct3 = f3;
        in_pc = pc; in_imm = imm; in_rs1 = rs1; in_rs2 = rs2;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        in_opcode = 7'($urandom); in_funct3 = 3'($urandom);
        in_pc = $urandom; in_imm = $urandom; in_rs1 = $urandom; in_rs2 = $urandom;
    endtask

    task automatic expect_result(input string tag, input logic tk, input logic [31:0] tgt,
                                 input logic [31:0] lnk, input logic ill, input logic mis);
        @(negedge CLK);
        check_eq({tag, "_valid"}, out_valid, 1);
        check_eq({tag, "_taken"}, out_taken, tk);
        check_eq({tag, "_target"}, out_target, tgt);
        check_eq({tag, "_link"}, out_link, lnk);
        check_eq({tag, "_illegal"}, out_illegal, ill);
        check_eq({tag, "_misalign"}, out_misalign, mis);
        check_eq({tag, "_in_ready"}, in_ready, 0);
        check_eq({tag, "_busy"}, busy, 1);
        check_eq({tag, "_flush"}, flush, 0);
    endtask

    task automatic handshake(input logic is_cbr, input logic tk);
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        if (is_cbr) begin
            exp_br++;
            if (tk) exp_tk++;
        end
    endtask

    // Holds in_valid high through the flush window; it must not be accepted.
    task automatic expect_flush(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check_eq({tag, "_flush_on"}, flush, 1);
            check_eq({tag, "_flush_ready"}, in_ready, 0);
            check_eq({tag, "_flush_busy"}, busy, 1);
            check_eq({tag, "_flush_ovalid"}, out_valid, 0);
            in_valid = 1'b1;
        end
        @(negedge CLK);
        in_valid = 1'b0;
        check_eq({tag, "_flush_off"}, flush, 0);
        check_eq({tag, "_idle_ready"}, in_ready, 1);
        check_eq({tag, "_idle_busy"}, busy, 0);
        check_eq({tag, "_idle_ovalid"}, out_valid, 0);
    endtask

    task automatic expect_idle(input string tag);
        @(negedge CLK);
        check_eq({tag, "_noflush"}, flush, 0);
        check_eq({tag, "_idle_ready"}, in_ready, 1);
        check_eq({tag, "_idle_busy"}, busy, 0);
        check_eq({tag, "_idle_ovalid"}, out_valid, 0);
    endtask

    task automatic check_stats(input string tag);
`ifdef BRC_STATS_EN
        check_eq({tag, "_stat_br"}, stat_branches, exp_br);
        check_eq({tag, "_stat_tk"}, stat_taken, exp_tk);
`else
        check_eq({tag, "_stat_br"}, stat_branches, 0);
        check_eq({tag, "_stat_tk"}, stat_taken, 0);
`endif
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_taken", out_taken, 0);
        check_eq("rst_illegal", out_illegal, 0);
        check_eq("rst_misalign", out_misalign, 0);
        check_eq("rst_flush", flush, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_target", out_target, 0);
        check_eq("rst_link", out_link, 0);
        check_eq("rst_stat_br", stat_branches, 0);
        check_eq("rst_stat_tk", stat_taken, 0);

        // Release and accept on the very first rising edge.
        RST_N = 1'b1;
        send(BR, 3'b000, 32'h100, 32'h20, 32'h5, 32'h5);
        expect_result("beq", 1, 32'h120, 32'h104, 0, 0);
        handshake(1, 1);
        expect_flush("beq", FC);

        send(BR, 3'b100, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'h1);
        expect_result("blt", 1, 32'h210, 32'h204, 0, 0);
        handshake(1, 1);
        expect_flush("blt", FC);

        send(BR, 3'b110, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'h1);
        expect_result("bltu", 0, 32'h210, 32'h204, 0, 0);
        handshake(1, 0);
        expect_idle("bltu");

        send(JALR, 3'b000, 32'h300, 32'h0, 32'h203, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check_eq("jalr_hold_valid", out_valid, 1);
            check_eq("jalr_hold_target", out_target, 32'h202);
            check_eq("jalr_hold_taken", out_taken, 1);
            check_eq("jalr_hold_flush", flush, 0);
        end
        check_eq("jalr_misalign", out_misalign, 1);
        check_eq("jalr_link", out_link, 32'h304);
        handshake(0, 1);
        expect_idle("jalr");

        send(BR, 3'b001, 32'h40, 32'h8, 32'h3, 32'h3);
        expect_result("bne", 0, 32'h48, 32'h44, 0, 0);
        handshake(1, 0);
        expect_idle("bne");

        send(BR, 3'b010, 32'h500, 32'h40, 32'h1, 32'h2);
        expect_result("br010", 0, 32'h504, 32'h504, 1, 0);
        handshake(0, 0);
        expect_idle("br010");

        send(JAL, 3'b000, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0);
        expect_result("jal_wrap", 1, 32'h4, 32'h0, 0, 0);
        handshake(0, 1);
        expect_flush("jal_wrap", FC);

        send(BR, 3'b101, 32'h600, 32'hFFFF_FFF0, 32'h1, 32'hFFFF_FFFF);
        expect_result("bge", 1, 32'h5F0, 32'h604, 0, 0);
        handshake(1, 1);
        expect_flush("bge", FC);

        send(BR, 3'b111, 32'h600, 32'h8, 32'h1, 32'hFFFF_FFFF);
        expect_result("bgeu", 0, 32'h608, 32'h604, 0, 0);
        handshake(1, 0);
        expect_idle("bgeu");

        send(7'b0110011, 3'b000, 32'h700, 32'h8, 32'h1, 32'h1);
        expect_result("badop", 0, 32'h704, 32'h704, 1, 0);
        handshake(0, 0);
        expect_idle("badop");

        check_stats("stats");

        // Reset during the first flush cycle.
        send(BR, 3'b000, 32'h100, 32'h20, 32'h7, 32'h7);
        expect_result("rstf", 1, 32'h120, 32'h104, 0, 0);
        handshake(1, 1);
        @(negedge CLK);
        check_eq("rstf_flush_before", flush, 1);
        RST_N = 1'b0; #1;
        check_eq("rstf_flush_dropped", flush, 0);
        check_eq("rstf_in_ready", in_ready, 1);
        check_eq("rstf_busy", busy, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        exp_br = 0; exp_tk = 0;
        repeat (3) begin
            @(negedge CLK);
            check_eq("rstf_no_ovalid", out_valid, 0);
            check_eq("rstf_no_flush", flush, 0);
        end
        check_stats("rstf");

        // Reset while a result is pending; it must not reappear.
        send(JAL, 3'b000, 32'h800, 32'h10, 32'h0, 32'h0);
        @(negedge CLK);
        check_eq("rstr_pending", out_valid, 1);
        RST_N = 1'b0; #1;
        check_eq("rstr_valid_dropped", out_valid, 0);
        check_eq("rstr_target_cleared", out_target, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check_eq("rstr_no_ovalid", out_valid, 0);
            check_eq("rstr_in_ready", in_ready, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, legal 1..7; number of flush cycles after a taken redirect.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. One clock; reset is asynchronous and active-low.
REQ-003 CLK  in  1  sole clock, rising edge.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1  instruction offered; in_ready  out  1  block accepts it.
REQ-006 in_opcode  in  7; in_funct3  in  3; in_pc  in  32; in_imm  in  32 (sign-extended B/J/I immediate); in_rs1, in_rs2  in  32 each.
REQ-007 out_valid  out  1  result held; out_ready  in  1  consumer accepts.
REQ-008 out_taken  out  1; out_target  out  32; out_link  out  32 (pc+4); out_illegal  out  1; out_misalign  out  1.
REQ-009 flush  out  1  front-end squash; busy  out  1  state is not IDLE.
REQ-010 stat_branches, stat_taken  out  32 each  counters (see Configuration).

Function
REQ-011 FSM states SHALL be IDLE, RESULT and FLUSH; in_ready SHALL be 1 only in IDLE.
REQ-012 IDLE: on in_valid&&in_ready, capture all in_* and go to RESULT; out_valid is high the next cycle (latency 1).
REQ-013 Captured operands SHALL be used; in_* changes after the handshake SHALL be ignored.
REQ-014 Conditional branch (opcode 1100011) compare: funct3 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
REQ-015 Branch target SHALL be pc+imm; JAL (1101111) SHALL be always taken with target pc+imm.
REQ-016 JALR (1100111) SHALL be always taken with target (rs1+imm) with bit0 cleared.
REQ-017 All additions SHALL be 32-bit modulo 2^32; wrap-around is silent.
REQ-018 out_link SHALL be pc+4 modulo 2^32 for every accepted instruction.
REQ-019 Branch funct3 010/011, or any other opcode, SHALL set out_illegal=1, out_taken=0, out_target=pc+4.
REQ-020 A taken result with target[1:0]!=0 SHALL set out_misalign=1, with out_taken=1.
REQ-021 RESULT SHALL hold all out_* stable until out_valid&&out_ready.
REQ-022 On the handshake: taken, legal and aligned results go to FLUSH; all other results go to IDLE.
REQ-023 FLUSH SHALL assert flush for exactly FLUSH_CYCLES consecutive cycles, then return to IDLE; in_valid is ignored throughout.
REQ-024 out_valid and flush SHALL never be high in the same cycle.
REQ-025 busy SHALL equal (state != IDLE).

Reset
REQ-026 RST_N low SHALL force IDLE asynchronously from any state, including mid-RESULT and mid-FLUSH.
REQ-027 Reset values SHALL be: in_ready=1; out_valid, out_taken, out_illegal, out_misalign, flush and busy = 0.
REQ-028 Reset values SHALL be: out_target, out_link, stat_branches and stat_taken = 0; the flush counter = 0.
REQ-029 An aborted transaction SHALL NOT be reported after reset release.
REQ-030 The first accept SHALL be possible on the first rising edge after RST_N deasserts.

Configuration
REQ-031 Macro BRC_STATS_EN SHALL compile in the statistics counters.
REQ-032 With BRC_STATS_EN defined, on each output handshake of a legal conditional branch, stat_branches SHALL increment.
REQ-033 With BRC_STATS_EN defined, stat_taken SHALL also increment on that handshake if out_taken=1.
REQ-034 With BRC_STATS_EN defined, both counters SHALL saturate at 0xFFFFFFFF.
REQ-035 Without BRC_STATS_EN, both stat outputs SHALL be constant 0 and no counter flops SHALL be inferred.

Verification
REQ-036 BEQ, rs1=rs2=0x5, pc=0x100, imm=0x20 -> out_taken=1, target 0x120, link 0x104; flush high 2 cycles; in_ready low until IDLE.
REQ-037 BLT, rs1=0xFFFFFFFF, rs2=0x1 -> taken. BLTU with the same operands -> not taken, no flush, back to IDLE after the handshake.
REQ-038 JALR, rs1=0x203, imm=0x0, out_ready held low 5 cycles -> out_valid stays high and stable, target 0x202; misalign=1 after the handshake with no flush.
REQ-039 Branch funct3=010 -> out_illegal=1, out_taken=0. JAL with pc=0xFFFFFFFC, imm=0x8 -> target 0x4 (wrap); link 0x0.
REQ-040 RST_N pulsed low during FLUSH cycle 1 -> flush drops immediately, state IDLE, in_ready=1; no out_valid after release.
REQ-041 With BRC_STATS_EN, 3 taken and 2 not-taken branches -> stat_branches=5, stat_taken=3; without the macro both stat outputs read 0.
